// File: rtl/agc_mem_arbiter_pkg.sv
// Shared types and constants for the AGC memory arbiter and related datapath blocks.
package agc_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RESP,
        CREAD,
        CCALC,
        CWRITE
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_CPU,
        REQ_CTR,
        REQ_EXT
    } req_id_t;

    // Odd parity over the 15 data bits of a memory word.
    function automatic logic odd_parity(input logic [DATA_W-2:0] w);
        return ~^w;
    endfunction

endpackage

// File: rtl/agc_mem_arbiter_if.sv
// Requester and memory-port bundle shared by the arbiter (slave) and its clients (master).
interface agc_mem_arbiter_if;
    import agc_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ctr_req;
    logic              ctr_dir;
    logic [ADDR_W-1:0] ctr_addr;
    logic              ctr_ack;
    logic              ctr_ovf;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ctr_req, ctr_dir, ctr_addr,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, ctr_ack, ctr_ovf, ext_ack, ext_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ctr_req, ctr_dir, ctr_addr,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, ctr_ack, ctr_ovf, ext_ack, ext_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/agc_mem_arbiter_inc.sv
// 15-bit one's-complement +1/-1 with end-around carry and overflow flag.
module ones_comp_inc (
    input  logic [14:0] v,
    input  logic        dir,
    output logic [14:0] r,
    output logic        ovf
);

    logic [14:0] addend;
    logic [15:0] sum;

    always_comb begin
        addend = dir ? 15'h7FFE : 15'h0001;
        sum    = {1'b0, v} + {1'b0, addend};
        r      = sum[14:0] + {14'd0, sum[15]};
        ovf    = (v[14] == addend[14]) && (r[14] != v[14]);
    end

endmodule

// File: rtl/agc_mem_arbiter.sv
// Cycle-stealing arbiter for the AGC memory port: CPU/loader plain accesses plus counter RMW.
// Define ARB_STARVE_GUARD_EN to let a waiting CPU win after STARVE_LIMIT back-to-back RMWs.
module agc_mem_arbiter
    import agc_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    agc_mem_arbiter_if.slave   bus,
    output logic               busy
);

    arb_state_t        state, state_nxt;
    req_id_t           win, gnt;
    logic              gnt_valid;
    logic              cpu_first;
    logic              lat_we;
    logic              lat_dir;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [14:0]       v;
    logic [14:0]       inc_r;
    logic              inc_ovf;
    logic [DATA_W-1:0] resp_data;

    ones_comp_inc u_inc (
        .v   (v),
        .dir (lat_dir),
        .r   (inc_r),
        .ovf (inc_ovf)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign cpu_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (state == IDLE && gnt_valid && gnt == REQ_CPU)
            starve_cnt <= '0;
        else if (state == CWRITE && bus.cpu_req && !cpu_first)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign cpu_first = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= REQ_CPU;
            lat_we    <= 1'b0;
            lat_dir   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            v         <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_valid) begin
                win <= gnt;
                unique case (gnt)
                    REQ_CPU: begin
                        lat_we    <= bus.cpu_we;
                        lat_addr  <= bus.cpu_addr;
                        lat_wdata <= bus.cpu_wdata;
                    end
                    REQ_CTR: begin
                        lat_we   <= 1'b0;
                        lat_dir  <= bus.ctr_dir;
                        lat_addr <= bus.ctr_addr;
                    end
                    default: begin
                        lat_we    <= bus.ext_we;
                        lat_addr  <= bus.ext_addr;
                        lat_wdata <= bus.ext_wdata;
                    end
                endcase
            end
            if (state == CCALC)
                v <= bus.mem_rdata[14:0];
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        gnt_valid = 1'b0;
        gnt       = REQ_CPU;
        if (bus.cpu_req && (cpu_first || !bus.ctr_req)) begin
            gnt_valid = 1'b1;
            gnt       = REQ_CPU;
        end else if (bus.ctr_req) begin
            gnt_valid = 1'b1;
            gnt       = REQ_CTR;
        end else if (bus.ext_req) begin
            gnt_valid = 1'b1;
            gnt       = REQ_EXT;
        end
        unique case (state)
            IDLE:    if (gnt_valid) state_nxt = (gnt == REQ_CTR) ? CREAD : ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            CREAD:   state_nxt = CCALC;
            CCALC:   state_nxt = CWRITE;
            CWRITE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.ctr_ack   = 1'b0;
        bus.ctr_ovf   = 1'b0;
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = '0;
        busy          = (state != IDLE);
        resp_data     = lat_we ? '0 : bus.mem_rdata;
        unique case (state)
            ISSUE: begin
                bus.mem_addr  = lat_addr;
                bus.mem_we    = lat_we;
                bus.mem_wdata = lat_wdata;
            end
            RESP: begin
                if (win == REQ_CPU) begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_rdata = resp_data;
                end else begin
                    bus.ext_ack   = 1'b1;
                    bus.ext_rdata = resp_data;
                end
            end
            CREAD, CCALC: bus.mem_addr = lat_addr;
            CWRITE: begin
                bus.mem_addr  = lat_addr;
                bus.mem_wdata = {odd_parity(inc_r), inc_r};
                bus.mem_we    = 1'b1;
                bus.ctr_ack   = 1'b1;
                bus.ctr_ovf   = inc_ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Self-checking bench for agc_mem_arbiter: vector table plus priority, starvation and reset sequences.
module tb_agc_mem_arbiter;
    import agc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    agc_mem_arbiter_if bus ();

    agc_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    // Memory model: registered read, data valid the cycle after the address.
    logic [15:0] mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        req_id_t     src;
        logic        op;       // we for plain access, dir for counter
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] init;     // memory contents before the access
        logic [15:0] exp;      // rdata for plain access, written word for counter
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic drive_req(input req_id_t s, input logic op, input logic [11:0] a,
                             input logic [15:0] d);
        case (s)
            REQ_CPU: begin
                bus.cpu_we = op; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
            end
            REQ_CTR: begin
                bus.ctr_dir = op; bus.ctr_addr = a; bus.ctr_req = 1'b1;
            end
            default: begin
                bus.ext_we = op; bus.ext_addr = a; bus.ext_wdata = d; bus.ext_req = 1'b1;
            end
        endcase
    endtask

    task automatic drop_req(input req_id_t s);
        case (s)
            REQ_CPU: bus.cpu_req = 1'b0;
            REQ_CTR: bus.ctr_req = 1'b0;
            default: bus.ext_req = 1'b0;
        endcase
    endtask

    function automatic logic ack_of(input req_id_t s);
        case (s)
            REQ_CPU: return bus.cpu_ack;
            REQ_CTR: return bus.ctr_ack;
            default: return bus.ext_ack;
        endcase
    endfunction

    function automatic logic [15:0] rdata_of(input req_id_t s);
        return (s == REQ_CPU) ? bus.cpu_rdata : bus.ext_rdata;
    endfunction

    task automatic run_vec(input vec_t t, input string tag);
        preload(t.addr, t.init);
        drive_req(t.src, t.op, t.addr, t.wdata);
        if (t.src == REQ_CTR) begin
            @(negedge clk);
            check({tag, " cread addr"}, bus.mem_addr, t.addr);
            check({tag, " cread we"}, bus.mem_we, 0);
            check({tag, " cread busy"}, busy, 1);
            @(negedge clk);
            check({tag, " ccalc we"}, bus.mem_we, 0);
            check({tag, " ccalc ack"}, bus.ctr_ack, 0);
            @(negedge clk);
            check({tag, " cwrite addr"}, bus.mem_addr, t.addr);
            check({tag, " cwrite we"}, bus.mem_we, 1);
            check({tag, " cwrite wdata"}, bus.mem_wdata, t.exp);
            check({tag, " ctr_ack"}, bus.ctr_ack, 1);
            check({tag, " ctr_ovf"}, bus.ctr_ovf, t.exp_ovf);
            drop_req(t.src);
            @(negedge clk);
            check({tag, " idle busy"}, busy, 0);
            check({tag, " idle ack"}, bus.ctr_ack, 0);
            check({tag, " idle ovf"}, bus.ctr_ovf, 0);
            check({tag, " mem word"}, mem[t.addr], t.exp);
        end else begin
            @(negedge clk);
            check({tag, " issue addr"}, bus.mem_addr, t.addr);
            check({tag, " issue we"}, bus.mem_we, t.op);
            if (t.op) check({tag, " issue wdata"}, bus.mem_wdata, t.wdata);
            check({tag, " issue ack"}, ack_of(t.src), 0);
            check({tag, " issue busy"}, busy, 1);
            @(negedge clk);
            check({tag, " resp ack"}, ack_of(t.src), 1);
            check({tag, " resp rdata"}, rdata_of(t.src), t.exp);
            check({tag, " resp we"}, bus.mem_we, 0);
            drop_req(t.src);
            @(negedge clk);
            check({tag, " idle busy"}, busy, 0);
            check({tag, " idle ack"}, ack_of(t.src), 0);
            if (t.op) check({tag, " mem word"}, mem[t.addr], t.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int ack_cyc [3];
        int ack_cnt [3];
        int max_acks;
        int ctr_done;
        int ctr_at_cpu;
        int exp_at_cpu;

        vecs[0] = '{REQ_CPU, 1'b0, 12'h010, 16'h0000, 16'h1234, 16'h1234, 1'b0};
        vecs[1] = '{REQ_EXT, 1'b1, 12'h020, 16'hA5A5, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{REQ_CTR, 1'b0, 12'h025, 16'h0000, 16'h3FFF, 16'h4000, 1'b1};
        vecs[3] = '{REQ_CTR, 1'b1, 12'h030, 16'h0000, 16'h0000, 16'hFFFE, 1'b0};
        vecs[4] = '{REQ_CTR, 1'b0, 12'h031, 16'h0000, 16'hFFFF, 16'h0001, 1'b0};
        vecs[5] = '{REQ_CTR, 1'b1, 12'h032, 16'h0000, 16'hC000, 16'hBFFF, 1'b1};
        vecs[6] = '{REQ_CPU, 1'b1, 12'h011, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0};
        vecs[7] = '{REQ_EXT, 1'b0, 12'h040, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
        vecs[8] = '{REQ_CTR, 1'b0, 12'h033, 16'h0000, 16'h8005, 16'h8006, 1'b0};
        vecs[9] = '{REQ_CTR, 1'b1, 12'h034, 16'h0000, 16'h0001, 16'h7FFF, 1'b0};

        reset = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ctr_req = 1'b0; bus.ctr_dir = 1'b0; bus.ctr_addr = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset mem_we", bus.mem_we, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset mem_wdata", bus.mem_wdata, 0);
        check("reset acks", {bus.cpu_ack, bus.ctr_ack, bus.ext_ack}, 0);
        check("reset ovf", bus.ctr_ovf, 0);
        check("reset rdata", {bus.cpu_rdata, bus.ext_rdata}, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // All three requesters in the same cycle: expect ctr, cpu, ext at cycles 3, 6, 9.
        preload(12'h050, 16'h0010);
        drive_req(REQ_CTR, 1'b0, 12'h050, 16'h0000);
        drive_req(REQ_CPU, 1'b0, 12'h050, 16'h0000);
        drive_req(REQ_EXT, 1'b0, 12'h050, 16'h0000);
        ack_cyc = '{-1, -1, -1};
        ack_cnt = '{0, 0, 0};
        max_acks = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (int'(bus.cpu_ack) + int'(bus.ctr_ack) + int'(bus.ext_ack) > max_acks)
                max_acks = int'(bus.cpu_ack) + int'(bus.ctr_ack) + int'(bus.ext_ack);
            if (bus.cpu_ack) begin ack_cnt[0]++; if (ack_cyc[0] < 0) ack_cyc[0] = c; bus.cpu_req = 1'b0; end
            if (bus.ctr_ack) begin ack_cnt[1]++; if (ack_cyc[1] < 0) ack_cyc[1] = c; bus.ctr_req = 1'b0; end
            if (bus.ext_ack) begin ack_cnt[2]++; if (ack_cyc[2] < 0) ack_cyc[2] = c; bus.ext_req = 1'b0; end
        end
        check("prio ctr ack cycle", ack_cyc[1], 3);
        check("prio cpu ack cycle", ack_cyc[0], 6);
        check("prio ext ack cycle", ack_cyc[2], 9);
        check("prio ack pulses", {ack_cnt[0][7:0], ack_cnt[1][7:0], ack_cnt[2][7:0]}, 32'h010101);
        check("prio one ack per cycle", max_acks, 1);
        check("prio cpu rdata path mem", mem[12'h050], 16'h8011);

        // Counter held for 6 RMWs while the CPU waits.
        preload(12'h060, 16'h0000);
        preload(12'h061, 16'h0777);
        drive_req(REQ_CTR, 1'b0, 12'h060, 16'h0000);
        drive_req(REQ_CPU, 1'b0, 12'h061, 16'h0000);
        ctr_done = 0;
        ctr_at_cpu = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.ctr_ack) begin
                ctr_done++;
                if (ctr_done == 6) bus.ctr_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                if (ctr_at_cpu < 0) ctr_at_cpu = ctr_done;
                bus.cpu_req = 1'b0;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_at_cpu = 4;
`else
        exp_at_cpu = 6;
`endif
        check("starve ctr rmw count", ctr_done, 6);
        check("starve ctr acks before cpu", ctr_at_cpu, exp_at_cpu);
        check("starve counter cell", mem[12'h060], 16'h8006);
        check("starve idle busy", busy, 0);

        // Reset during CCALC abandons the RMW.
        preload(12'h070, 16'h0100);
        drive_req(REQ_CTR, 1'b0, 12'h070, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("rst ccalc busy", busy, 1);
        reset = 1'b1;
        bus.ctr_req = 1'b0;
        @(negedge clk);
        check("rst mem_we", bus.mem_we, 0);
        check("rst ctr_ack", bus.ctr_ack, 0);
        check("rst busy", busy, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst idle busy", busy, 0);
        check("rst cell untouched", mem[12'h070], 16'h0100);
        run_vec('{REQ_CPU, 1'b0, 12'h070, 16'h0000, 16'h0100, 16'h0100, 1'b0}, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/agc_mem_arbiter.md
# agc_mem_arbiter

Cycle-stealing memory scheduler that shares the AGC's single erasable/fixed memory port among three requesters: the control-pulse sequencer (CPU), the counter-cell increment unit, and the external DSKY/uplink loader. CPU and loader accesses are plain reads or writes. Counter increments run as an atomic read-modify-write that the arbiter performs itself using 15-bit one's-complement arithmetic with parity regeneration. The block sits between the requesters and the memory module's address, data and write-enable pins.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 16, word width; bit 15 is parity, bits 14:0 are data
- STARVE_LIMIT, 4, consecutive counter RMWs allowed while CPU waits (guard build only)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req / cpu_we  in  1 / 1  CPU request; 1 = write
- cpu_addr / cpu_wdata  in  12 / 16  CPU address and write data
- cpu_ack / cpu_rdata  out  1 / 16  one-cycle completion pulse; read data, valid with ack
- ctr_req / ctr_dir  in  1 / 1  increment request; 0 = +1, 1 = −1
- ctr_addr  in  12  counter cell address
- ctr_ack / ctr_ovf  out  1 / 1  RMW done; overflow, valid with ack
- ext_req / ext_we / ext_addr / ext_wdata  in  1/1/12/16  loader request fields
- ext_ack / ext_rdata  out  1 / 16  loader completion and read data
- mem_addr / mem_wdata / mem_we  out  12/16/1  shared memory port
- mem_rdata  in  16  memory data; valid the cycle after mem_addr is presented
- busy  out  1  high in every state except IDLE

## Operation
- Requester contract: hold req and all fields stable until the ack pulse. Drop req, or change fields, only after the ack cycle.
- Priority in IDLE: ctr > cpu > ext. The winner and its fields are latched at the arbitration edge.
- States and transitions:
  - Plain access: IDLE → ISSUE → RESP → IDLE.
  - Counter RMW: IDLE → CREAD → CCALC → CWRITE → IDLE.
- ISSUE: drive the latched address; mem_we = latched we; mem_wdata = latched wdata, unmodified.
- RESP: pulse the winner's ack; rdata = mem_rdata for reads and 0 for writes.
- CREAD: mem_addr = ctr_addr, mem_we = 0.
- CCALC: capture mem_rdata[14:0] into v and compute the result r.
- CWRITE: mem_addr = ctr_addr; mem_wdata = {~^r, r} (odd parity); mem_we = 1; pulse ctr_ack and ctr_ovf.
- Arithmetic is 15-bit one's complement:
  - +1 adds 15'h0001; −1 adds 15'h7FFE.
  - A carry out of bit 14 is added back in (end-around carry).
  - Overflow occurs when the operand signs (bit 14) are equal and the result sign differs. The wrapped r is still written.
  - Examples: 3FFF+1 → 4000, ovf. 7FFF(−0)+1 → 0001. 0000−1 → 7FFE. 4000−1 → 3FFF, ovf.
- Reset (any state): next state IDLE. All outputs and the starvation counter go to 0. An in-flight access is abandoned: no ack, and mem_we is low from the cycle after reset is sampled.
- Outputs out of reset: acks 0, rdata 0, ctr_ovf 0, mem_* 0, busy 0.

## Timing
- Request first seen high in IDLE at edge t:
  - Plain access: mem port driven in cycle t+1, ack at t+2, IDLE at t+3.
  - Counter RMW: read at t+1, write plus ack at t+3, IDLE at t+4.
- Throughput: one plain access per 3 cycles, one RMW per 4 cycles.
- A requester still asserting req at IDLE re-arbitrates normally. The arbiter never grants twice on a single held request: a requester must deassert req for at least the cycle after its ack.
- ctr_ovf is valid only while ctr_ack = 1. All other cycles it is 0.
- All ack pulses are exactly 1 cycle long, and at most one ack is high in any cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on every completed RMW while cpu_req is high, and clears on any CPU grant.
  - At STARVE_LIMIT, CPU wins the next arbitration over ctr.
- ARB_STARVE_GUARD_EN undefined: strict priority; CPU waits while ctr_req stays high.

## Structure
- Shared package (agc_pkg): ADDR_W/DATA_W constants, the arb_state_t enum (IDLE, ISSUE, RESP, CREAD, CCALC, CWRITE) and the requester-ID enum (REQ_CPU, REQ_CTR, REQ_EXT).
- Sub-module ones_comp_inc: combinational; inputs v[14:0] and dir; outputs r[14:0] and ovf. It is reused later by the ALU.
- The rest lives in one module: FSM, latched request, starvation counter and output muxing.

## Test plan
- CPU read 0x010, memory holds 0x1234 → cpu_ack at t+2 with cpu_rdata = 0x1234; mem_we never high.
- Loader write 0x020 ← 0xA5A5 → mem_we = 1 in cycle t+1 with mem_wdata = 0xA5A5; ext_ack at t+2.
- Counter +1 at cell 0x025 holding 0x3FFF → write 0x4000 in cycle t+3; ctr_ack = 1, ctr_ovf = 1.
- Counter −1 at a cell holding 0x0000 → write 0xFFFE (parity bit 1); ctr_ovf = 0.
- cpu, ctr and ext requests all raised in the same cycle → service order ctr, cpu, ext; acks at t+3, t+6, t+9. With guard, ctr held high for 6 RMWs and cpu_req high → cpu_ack follows the 4th ctr_ack. Without guard → cpu_ack only after ctr_req drops.
- Reset asserted during CCALC → no mem_we and no ctr_ack; state IDLE and busy = 0 on the next cycle; a new cpu_req is served normally.
